// File: rtl/lsu32_if.sv
// lsu32_if: request, memory-bus and response signals of the lsu32 load/store unit.
// master is the unit itself; slave is the execute/memory/writeback side.
interface lsu32_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_store;
  logic [4:0]  req_rd;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  modport master (
    input  req_valid, req_addr, req_wdata, req_funct3, req_store, req_rd,
    input  mem_ready, mem_rdata,
    output req_ready, mem_addr, mem_wdata, mem_wstrb, mem_rd, mem_wr,
    output resp_valid, resp_data, resp_rd, resp_err
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_funct3, req_store, req_rd,
    output mem_ready, mem_rdata,
    input  req_ready, mem_addr, mem_wdata, mem_wstrb, mem_rd, mem_wr,
    input  resp_valid, resp_data, resp_rd, resp_err
  );
endinterface

// File: rtl/lsu32.sv
// lsu32: RV32I memory-stage load/store unit on a ready-handshake data bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of truncating the address.
//
// state | meaning
// IDLE  | accepting a request (req_ready high)
// BUS   | read/write strobe held, waiting for mem_ready or timeout
// RESP  | one-cycle completion pulse to writeback
module lsu32 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic    clk,
  input  logic    reset,
  lsu32_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [4:0]  rd_q;
  logic [7:0]  tcnt;

  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;

  logic [31:0] resp_data_q;
  logic [4:0]  resp_rd_q;
  logic        resp_err_q;

  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        misalign;
  logic        timeout;

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1] set selects a word access (W and the reserved encodings)
  assign misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                    (bus.req_funct3[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign timeout = (tcnt == TC_LAST);

  always_comb begin
    lane_wdata = bus.req_wdata;
    lane_wstrb = 4'b1111;
    case (bus.req_funct3[1:0])
      2'b00: begin
        lane_wdata = {4{bus.req_wdata[7:0]}};
        lane_wstrb = 4'b0001 << bus.req_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{bus.req_wdata[15:0]}};
        lane_wstrb = 4'b0011 << {bus.req_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = bus.mem_rdata[7:0];
    case (addr_lo_q)
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      2'd3:    ld_byte = bus.mem_rdata[31:24];
      default: ld_byte = bus.mem_rdata[7:0];
    endcase
    ld_half = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld_ext  = bus.mem_rdata;
    case (funct3_q[1:0])
      2'b00:   ld_ext = funct3_q[2] ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = funct3_q[2] ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = misalign ? RESP : BUS;
      BUS:     if (bus.mem_ready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      store_q     <= 1'b0;
      rd_q        <= 5'd0;
      tcnt        <= 8'd0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      resp_data_q <= 32'h0;
      resp_rd_q   <= 5'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_lo_q <= bus.req_addr[1:0];
            funct3_q  <= bus.req_funct3;
            store_q   <= bus.req_store;
            rd_q      <= bus.req_rd;
            tcnt      <= 8'd0;
            if (misalign) begin
              resp_data_q <= 32'h0;
              resp_rd_q   <= bus.req_store ? 5'd0 : bus.req_rd;
              resp_err_q  <= 1'b1;
            end else begin
              mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
              mem_wdata_q <= lane_wdata;
              mem_wstrb_q <= lane_wstrb;
            end
          end
        end
        BUS: begin
          // a completing mem_ready wins over a timeout in the same cycle
          if (bus.mem_ready) begin
            resp_data_q <= store_q ? 32'h0 : ld_ext;
            resp_rd_q   <= store_q ? 5'd0 : rd_q;
            resp_err_q  <= 1'b0;
          end else if (timeout) begin
            resp_data_q <= 32'h0;
            resp_rd_q   <= store_q ? 5'd0 : rd_q;
            resp_err_q  <= 1'b1;
          end else if (tcnt != 8'hFF) begin
            tcnt <= tcnt + 8'd1;
          end
        end
        RESP: begin
          resp_data_q <= 32'h0;
          resp_rd_q   <= 5'd0;
          resp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // strobes decode from state so an asynchronous reset drops them at once
  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_rd     = (state == BUS) && !store_q;
  assign bus.mem_wr     = (state == BUS) && store_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wstrb  = bus.mem_wr ? mem_wstrb_q : 4'b0000;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: doc/lsu32.md
# lsu32

Load/store unit for the RV32I core's memory stage. It sits directly downstream of the 32-bit ALU: the ALU's ADD result is the effective address. The unit issues one byte, halfword or word access on a simple ready-handshake data bus. It returns aligned, sign- or zero-extended load data to writeback, tagged with the destination register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: bus cycles to wait for `mem_ready` before aborting with `resp_err`. Range 1..255.

Ports (clock is `clk`; reset is `reset`, asynchronous, active-high):
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous active-high reset
- `req_valid`  in  1  memory-op request from execute
- `req_ready`  out  1  unit idle, accepts request this cycle
- `req_addr`  in  32  effective address (ALU out)
- `req_wdata`  in  32  store data (rs2), right-justified
- `req_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_store`  in  1  1 = store, 0 = load
- `req_rd`  in  5  load destination register
- `mem_addr`  out  32  word-aligned bus address (`{addr[31:2],2'b00}`)
- `mem_wdata`  out  32  lane-replicated store data
- `mem_wstrb`  out  4  byte enables
- `mem_rd`  out  1  read strobe, held until `mem_ready`
- `mem_wr`  out  1  write strobe, held until `mem_ready`
- `mem_ready`  in  1  bus completes access this cycle
- `mem_rdata`  in  32  read data, valid with `mem_ready`
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_data`  out  32  extended load data; 0 for stores and errors
- `resp_rd`  out  5  destination register; 0 for stores
- `resp_err`  out  1  timeout or misaligned (see Configuration)

## Operation
- FSM states: IDLE, BUS, RESP.
  - IDLE: `req_ready`=1. If `req_valid`, register addr, funct3, store, rd and wdata, then go to BUS. A misaligned access with the trap enabled goes to RESP with err instead.
  - BUS: `mem_rd` or `mem_wr` is high and bus outputs are stable. On `mem_ready`, capture `mem_rdata` and go to RESP. If the timeout counter reaches `TIMEOUT_CYCLES` without `mem_ready`, go to RESP with err.
  - RESP: `resp_valid`=1 for exactly one cycle, then IDLE. There is no backpressure; writeback always consumes.
- Store lanes:
  - B: wdata = `{4{wdata[7:0]}}`, wstrb = `0001 << addr[1:0]`.
  - H: wdata = `{2{wdata[15:0]}}`, wstrb = `0011 << {addr[1],1'b0}`.
  - W: wdata unchanged, wstrb = `1111`.
- Loads: select the byte/half by `addr[1:0]`. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Reserved funct3 (011, 110, 111) are treated as W.
- Timeout counter: 8-bit, cleared on entering BUS, saturates.
- Reset values:
  - FSM = IDLE.
  - All `mem_*` strobes and `mem_wstrb` = 0; `mem_addr` and `mem_wdata` = 0.
  - `resp_valid` = 0, `resp_err` = 0, `resp_data` = 0, `resp_rd` = 0.
  - `req_ready` = 1 after reset.
- Reset asserted mid-BUS drops the strobes immediately (asynchronous); no response is issued.

## Timing
- Accept edge N. Strobes are high from cycle N+1.
- If `mem_ready` is high in cycle N+1, `resp_valid` is high in cycle N+2. Minimum request-to-response latency is 2 cycles.
- `req_ready` is low from N+1 through the RESP cycle and high again the cycle after RESP. Maximum throughput is one access per 3 cycles.
- `mem_ready` sampled while not in BUS is ignored.
- A timeout produces RESP at cycle N+1+`TIMEOUT_CYCLES`. A `mem_ready` arriving after the abort is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - H with `addr[0]`=1, or W with `addr[1:0]`≠0, issues no bus access.
  - The unit goes IDLE→RESP, and `resp_valid`=1 with `resp_err`=1 and `resp_data`=0 at N+1.
- Undefined:
  - Low address bits below the access size are ignored: H uses `addr[1]` only, W uses the full word.
  - `resp_err` is only ever set by timeout.

## Test plan
- Load word: LW addr 0x100, `mem_ready` at N+1, rdata 0xDEADBEEF -> `mem_addr`=0x100, `resp_valid` at N+2, `resp_data`=0xDEADBEEF, `resp_rd` echoed.
- Byte sign/zero extend: LB and LBU at 0x103 with rdata 0x80123456 -> 0xFFFFFF80 and 0x00000080. LH at 0x102 -> 0xFFFF8012.
- Store lanes: SB 0xAB at 0x101 -> wstrb 0010, wdata 0xABABABAB. SH 0x1234 at 0x102 -> wstrb 1100, wdata 0x12341234. `resp_data`=0, `resp_rd`=0.
- Wait states: `mem_ready` delayed 5 cycles -> strobes and address stable throughout; exactly one `resp_valid`; `req_ready` low until after RESP.
- Timeout: `TIMEOUT_CYCLES`=4, `mem_ready` never -> `resp_err`=1 at N+5; a later `mem_ready` pulse is ignored.
- Misaligned/reset:
  - LW at 0x102: with the macro, `resp_err` at N+1 and no strobe; without it, a read of 0x100.
  - Reset mid-BUS: strobes drop immediately, no `resp_valid`, `req_ready`=1 after release.
